// File: rtl/pc_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory port plus the decode-facing head of the fetch buffer.
// Decode handshake: an entry moves exactly in a cycle where id_valid && id_ready at the rising edge;
// id_valid never depends on id_ready, and id_inst/id_pc/id_pc4 are stable while id_valid is high and not accepted.
interface pc_fetch_if;
    logic [31:0] im_addr;
    logic        im_r;
    logic [31:0] im_rd;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    modport master (
        output im_addr, im_r, id_valid, id_inst, id_pc, id_pc4,
        input  im_rd, id_ready
    );

    modport slave (
        input  im_addr, im_r, id_valid, id_inst, id_pc, id_pc4,
        output im_rd, id_ready
    );
endinterface

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the PC, reads imem combinationally and queues {pc, inst}
// pairs in a small FIFO toward decode; a redirect flushes the queue and reloads the PC.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    pc_fetch_if.master  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (RESET_PC[1:0] != 2'b00)) begin : g_bad_param
        $error("pc_fetch: DEPTH must be a power of 2 >= 2 and RESET_PC word aligned");
    end

    logic [31:0]   pc;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   buf_pc   [DEPTH];
    logic [31:0]   buf_inst [DEPTH];

    logic fetch;
    logic deq;
    logic head_valid;

    // Full check uses only the registered count, so id_ready never reaches im_r.
    assign fetch      = rst_n & fetch_en & ~redirect & (count < FULL);
    assign head_valid = (count != '0);
    assign deq        = head_valid & bus.id_ready;

    assign bus.im_addr = pc;
    assign bus.im_r    = fetch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            // Flush wins over any concurrent fetch or dequeue.
            pc     <= {redirect_pc[31:2], 2'b00};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fetch) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({fetch, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (fetch) begin
            buf_pc[wr_ptr]   <= pc;
            buf_inst[wr_ptr] <= bus.im_rd;
        end
    end

    assign bus.id_valid = head_valid;
    assign bus.id_inst  = head_valid ? buf_inst[rd_ptr] : 32'h0;
    assign bus.id_pc    = head_valid ? buf_pc[rd_ptr] : 32'h0;
    assign bus.id_pc4   = head_valid ? (buf_pc[rd_ptr] + 32'd4) : 32'h0;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: streaming, back-pressure, redirects, fetch_en gating,
// async reset mid-stream, and PC wrap on a second instance with a high RESET_PC.
module tb_pc_fetch;

    logic        clk;
    logic        rst_n;
    logic        rst_n_w;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_checks;
    int n_errors;

    pc_fetch_if bus ();
    pc_fetch_if bus_w ();

    pc_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus)
    );

    pc_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
        .clk         (clk),
        .rst_n       (rst_n_w),
        .fetch_en    (1'b1),
        .redirect    (1'b0),
        .redirect_pc (32'h0),
        .bus         (bus_w)
    );

    // imem model: word k holds 32'h1000_0000 + k
    assign bus.im_rd   = 32'h1000_0000 + {2'b00, bus.im_addr[31:2]};
    assign bus_w.im_rd = 32'h1000_0000 + {2'b00, bus_w.im_addr[31:2]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [31:0] pc_got,
                            input logic [31:0] inst_got, input logic [31:0] pc4_got,
                            input logic [31:0] exp_pc, input logic [31:0] exp_inst);
        check({tag, "_valid"}, {31'h0, v}, 32'h1);
        check({tag, "_pc"}, pc_got, exp_pc);
        check({tag, "_inst"}, inst_got, exp_inst);
        check({tag, "_pc4"}, pc4_got, exp_pc + 32'd4);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        rst_n_w     = 1'b0;
        fetch_en    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        bus.id_ready   = 1'b1;
        bus_w.id_ready = 1'b1;

        repeat (2) cyc();
        check("rst_im_r", {31'h0, bus.im_r}, 32'h0);
        check("rst_valid", {31'h0, bus.id_valid}, 32'h0);
        check("rst_id_pc", bus.id_pc, 32'h0);
        check("rst_id_inst", bus.id_inst, 32'h0);
        check("rst_id_pc4", bus.id_pc4, 32'h0);
        check("rst_im_addr", bus.im_addr, 32'h0);

        // Streaming from reset with decode always ready
        rst_n = 1'b1;
        #1;
        check("t1_c0_im_r", {31'h0, bus.im_r}, 32'h1);
        check("t1_c0_addr", bus.im_addr, 32'h0);
        check("t1_c0_valid", {31'h0, bus.id_valid}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            #1;
            chk_head("t1_head", bus.id_valid, bus.id_pc, bus.id_inst, bus.id_pc4,
                     32'(4 * k), 32'h1000_0000 + 32'(k));
            check("t1_addr", bus.im_addr, 32'(4 * (k + 1)));
            check("t1_im_r", {31'h0, bus.im_r}, 32'h1);
        end

        // Back-pressure: restart with decode stalled
        rst_n = 1'b0;
        bus.id_ready = 1'b0;
        #1;
        check("t2_rst_im_r", {31'h0, bus.im_r}, 32'h0);
        check("t2_rst_valid", {31'h0, bus.id_valid}, 32'h0);
        cyc();
        rst_n = 1'b1;
        #1;
        check("t2_c0_im_r", {31'h0, bus.im_r}, 32'h1);
        for (int k = 1; k < 5; k++) begin
            cyc();
            #1;
            check("t2_stall_im_r", {31'h0, bus.im_r}, (k == 1) ? 32'h1 : 32'h0);
            check("t2_stall_addr", bus.im_addr, (k == 1) ? 32'h4 : 32'h8);
            check("t2_stall_pc", bus.id_pc, 32'h0);
        end
        cyc();
        bus.id_ready = 1'b1;
        #1;
        chk_head("t2_h0", bus.id_valid, bus.id_pc, bus.id_inst, bus.id_pc4, 32'h0, 32'h1000_0000);
        check("t2_full_im_r", {31'h0, bus.im_r}, 32'h0);
        cyc();
        #1;
        chk_head("t2_h4", bus.id_valid, bus.id_pc, bus.id_inst, bus.id_pc4, 32'h4, 32'h1000_0001);
        check("t2_refetch_im_r", {31'h0, bus.im_r}, 32'h1);
        check("t2_refetch_addr", bus.im_addr, 32'h8);
        cyc();
        #1;
        chk_head("t2_h8", bus.id_valid, bus.id_pc, bus.id_inst, bus.id_pc4, 32'h8, 32'h1000_0002);

        // Redirect with two buffered entries
        cyc();
        bus.id_ready = 1'b0;
        #1;
        check("t3_pre_pc", bus.id_pc, 32'hC);
        cyc();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        check("t3_redir_im_r", {31'h0, bus.im_r}, 32'h0);
        check("t3_redir_pc", bus.id_pc, 32'hC);
        cyc();
        redirect = 1'b0;
        bus.id_ready = 1'b1;
        #1;
        check("t3_flush_valid", {31'h0, bus.id_valid}, 32'h0);
        check("t3_flush_pc", bus.id_pc, 32'h0);
        check("t3_flush_inst", bus.id_inst, 32'h0);
        check("t3_new_addr", bus.im_addr, 32'h100);
        check("t3_new_im_r", {31'h0, bus.im_r}, 32'h1);
        cyc();
        bus.id_ready = 1'b0;
        #1;
        chk_head("t3_h100", bus.id_valid, bus.id_pc, bus.id_inst, bus.id_pc4, 32'h100, 32'h1000_0040);

        // Redirect + dequeue on a full buffer
        cyc();
        bus.id_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        #1;
        check("t4_full_pc", bus.id_pc, 32'h100);
        check("t4_full_im_r", {31'h0, bus.im_r}, 32'h0);
        cyc();
        redirect = 1'b0;
        #1;
        check("t4_flush_valid", {31'h0, bus.id_valid}, 32'h0);
        check("t4_new_addr", bus.im_addr, 32'h200);
        cyc();
        #1;
        chk_head("t4_h200", bus.id_valid, bus.id_pc, bus.id_inst, bus.id_pc4, 32'h200, 32'h1000_0080);

        // Back-to-back redirects, last one wins (low bits forced to 00)
        cyc();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0300;
        #1;
        chk_head("t4_h204", bus.id_valid, bus.id_pc, bus.id_inst, bus.id_pc4, 32'h204, 32'h1000_0081);
        cyc();
        redirect_pc = 32'h0000_0402;
        #1;
        check("t4_b2b_valid", {31'h0, bus.id_valid}, 32'h0);
        check("t4_b2b_addr", bus.im_addr, 32'h300);
        check("t4_b2b_im_r", {31'h0, bus.im_r}, 32'h0);
        cyc();
        redirect = 1'b0;
        #1;
        check("t4_last_valid", {31'h0, bus.id_valid}, 32'h0);
        check("t4_last_addr", bus.im_addr, 32'h400);
        cyc();
        #1;
        chk_head("t4_h400", bus.id_valid, bus.id_pc, bus.id_inst, bus.id_pc4, 32'h400, 32'h1000_0100);

        // fetch_en low: PC frozen, buffer drains
        cyc();
        fetch_en = 1'b0;
        #1;
        chk_head("fe_h404", bus.id_valid, bus.id_pc, bus.id_inst, bus.id_pc4, 32'h404, 32'h1000_0101);
        check("fe_im_r", {31'h0, bus.im_r}, 32'h0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            #1;
            check("fe_drained_valid", {31'h0, bus.id_valid}, 32'h0);
            check("fe_frozen_addr", bus.im_addr, 32'h408);
            check("fe_frozen_im_r", {31'h0, bus.im_r}, 32'h0);
        end
        cyc();
        fetch_en = 1'b1;
        #1;
        check("fe_resume_im_r", {31'h0, bus.im_r}, 32'h1);
        cyc();
        #1;
        chk_head("fe_h408", bus.id_valid, bus.id_pc, bus.id_inst, bus.id_pc4, 32'h408, 32'h1000_0102);

        // Short async reset pulse between edges
        rst_n = 1'b0;
        #1;
        check("t6_valid", {31'h0, bus.id_valid}, 32'h0);
        check("t6_im_r", {31'h0, bus.im_r}, 32'h0);
        check("t6_id_pc", bus.id_pc, 32'h0);
        rst_n = 1'b1;
        #1;
        check("t6_addr", bus.im_addr, 32'h0);
        check("t6_rel_im_r", {31'h0, bus.im_r}, 32'h1);
        check("t6_rel_valid", {31'h0, bus.id_valid}, 32'h0);
        cyc();
        #1;
        chk_head("t6_h0", bus.id_valid, bus.id_pc, bus.id_inst, bus.id_pc4, 32'h0, 32'h1000_0000);

        // PC wrap on the high RESET_PC instance
        cyc();
        rst_n_w = 1'b1;
        #1;
        check("t5_c0_addr", bus_w.im_addr, 32'hFFFF_FFF8);
        check("t5_c0_im_r", {31'h0, bus_w.im_r}, 32'h1);
        cyc();
        #1;
        chk_head("t5_hf8", bus_w.id_valid, bus_w.id_pc, bus_w.id_inst, bus_w.id_pc4,
                 32'hFFFF_FFF8, 32'h4FFF_FFFE);
        cyc();
        #1;
        chk_head("t5_hfc", bus_w.id_valid, bus_w.id_pc, bus_w.id_inst, bus_w.id_pc4,
                 32'hFFFF_FFFC, 32'h4FFF_FFFF);
        check("t5_hfc_pc4_zero", bus_w.id_pc4, 32'h0);
        cyc();
        #1;
        chk_head("t5_h0", bus_w.id_valid, bus_w.id_pc, bus_w.id_inst, bus_w.id_pc4,
                 32'h0, 32'h1000_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
